// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with prefetch FIFO for the 16-bit CPU.
// Owns fetch PC, issues one req/ack memory read at a time, buffers results.
//
// Ports:
//   clock, resetn          : clock, async active-low reset
//   mem_req/mem_addr       : instruction memory read request and byte address
//   mem_ack/mem_rdata      : memory completion and returned instruction word
//   ir_valid/ir/ir_pc      : FIFO head presented to the CPU
//   ir_ready               : CPU consumes head this cycle
//   redirect/redirect_pc   : flush FIFO and restart fetch at redirect_pc
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clock,
    input  logic        resetn,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    logic [15:0]   fetch_pc;
    logic [15:0]   buf_ir [DEPTH];
    logic [15:0]   buf_pc [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          space_nxt;
    logic          space_now;
    logic [15:0]   tgt;
    logic [15:0]   step_pc;
    logic [15:0]   dis_pc;

    assign tgt     = redirect_pc & 16'hFFFE;
    assign step_pc = fetch_pc + PC_STEP;
    assign dis_pc  = redirect ? tgt : fetch_pc;

    // Redirect kills both the returning word and the consumer's pop.
    assign push = (state == WAIT) && mem_ack && !redirect;
    assign pop  = ir_valid && ir_ready && !redirect;

    always_comb begin
        count_nxt = count;
        if (redirect) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
        end
    end

    // Space is judged at issue time, so an ack can never overflow.
    assign space_nxt = count_nxt < CW'(DEPTH);
    assign space_now = count < CW'(DEPTH);

    assign ir_valid = (count != '0);
    assign ir       = buf_ir[rptr];
    assign ir_pc    = buf_pc[rptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_ir[i] <= '0;
                buf_pc[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            if (redirect) begin
                rptr <= wptr;
            end else begin
                if (push) begin
                    buf_ir[wptr] <= mem_rdata;
                    buf_pc[wptr] <= mem_addr;
                    wptr         <= wptr + 1'b1;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
            end
        end
    end

    // In WAIT/DISCARD fetch_pc tracks the address the next request uses;
    // in DISCARD it already holds the redirect target.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= tgt;
                    end else if (space_now) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect && mem_ack) begin
                        fetch_pc <= tgt;
                        mem_addr <= tgt;
                    end else if (redirect) begin
                        fetch_pc <= tgt;
                        state    <= DISCARD;
                    end else if (mem_ack) begin
                        fetch_pc <= step_pc;
                        if (space_nxt) begin
                            mem_addr <= step_pc;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        fetch_pc <= dis_pc;
                        if (space_nxt) begin
                            mem_addr <= dis_pc;
                            state    <= WAIT;
                        end else begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (redirect) begin
                        fetch_pc <= tgt;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: scenario tasks plus randomized traffic
// against a queue-based model of the fetch rules.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;

    int checks = 0;
    int failures = 0;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .resetn(resetn),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .ir_valid(ir_valid),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_ready(ir_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    int          lat_lo = 0;
    int          lat_hi = 0;
    int          lat = 0;
    int          wcnt = 0;
    logic [15:0] dmask = 16'h0;
    logic        last_ack = 1'b0;

    logic [31:0] q[$];
    logic        m_req = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_next = 16'h0;
    logic        m_drop = 1'b0;

    function automatic logic [49:0] obs();
        return {mem_req, mem_req ? mem_addr : 16'h0,
                ir_valid, ir_valid ? {ir, ir_pc} : 32'h0};
    endfunction

    function automatic logic [49:0] expv();
        logic        v;
        logic [31:0] h;
        v = q.size() > 0;
        h = v ? q[0] : 32'h0;
        return {m_req, m_req ? m_addr : 16'h0, v, h};
    endfunction

    task automatic model_step(input logic rdy, input logic rd,
                              input logic [15:0] rpc, input logic ack,
                              input logic [15:0] rdata);
        logic had;
        logic done;
        int   sz0;
        had = m_req;
        done = m_req && ack;
        sz0 = q.size();
        if (rd) q.delete();
        else if (rdy && sz0 > 0) void'(q.pop_front());
        if (done) begin
            if (!rd && !m_drop) begin
                q.push_back({rdata, m_addr});
                m_next = m_addr + 16'd2;
            end
            m_drop = 1'b0;
        end
        if (rd) begin
            m_next = rpc & 16'hFFFE;
            if (had && !done) m_drop = 1'b1;
        end
        if (done) m_req = q.size() < DEPTH;
        else if (!had) m_req = (sz0 < DEPTH) && !rd;
        if (m_req && (done || !had)) m_addr = m_next;
    endtask

    task automatic cyc(input logic rdy, input logic rd, input logic [15:0] rpc);
        logic        req;
        logic        ack;
        logic [15:0] rdat;
        req = (mem_req === 1'b1);
        ack = req && (wcnt >= lat);
        rdat = mem_addr ^ dmask;
        ir_ready = rdy;
        redirect = rd;
        redirect_pc = rpc;
        mem_ack = ack;
        mem_rdata = rdat;
        @(posedge clock);
        model_step(rdy, rd, rpc, ack, rdat);
        last_ack = ack;
        if (ack) begin
            wcnt = 0;
            lat = int'($urandom_range(lat_hi, lat_lo));
        end else if (req) begin
            wcnt++;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        ir_ready = 1'b0;
        redirect = 1'b0;
        mem_ack = 1'b0;
        q.delete();
        m_req = 1'b0;
        m_addr = 16'h0;
        m_next = 16'h0;
        m_drop = 1'b0;
        wcnt = 0;
        lat = int'($urandom_range(lat_hi, lat_lo));
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, ir_valid, ir, ir_pc} !== 50'h0) begin
            failures++;
            $display("FAIL reset_vals got=%h exp=0",
                     {mem_req, mem_addr, ir_valid, ir, ir_pc});
        end
        lat_lo = 0; lat_hi = 0; dmask = 16'h0;
        do_reset();
        checks++;
        if (obs() !== expv()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_stream();
        lat_lo = 0; lat_hi = 0; dmask = 16'h0;
        do_reset();
        cyc(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL stream_model got=%h exp=%h", obs(), expv());
            end
            checks++;
            if (!(mem_req === 1'b1 && mem_addr === 16'(2 * i))) begin
                failures++;
                $display("FAIL stream_addr got=%b/%h exp=1/%h",
                         mem_req, mem_addr, 16'(2 * i));
            end
            if (i > 0) begin
                checks++;
                if (!(ir_valid === 1'b1 && ir_pc === 16'(2 * (i - 1))
                      && ir === ir_pc)) begin
                    failures++;
                    $display("FAIL stream_ir got=%b/%h/%h exp=1/%h",
                             ir_valid, ir, ir_pc, 16'(2 * (i - 1)));
                end
            end
            cyc(1'b1, 1'b0, 16'h0);
        end
    endtask

    task automatic test_full();
        int   acks;
        int   popcnt;
        logic seen;
        lat_lo = 0; lat_hi = 0; dmask = 16'(($urandom));
        do_reset();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 16'h0);
            if (last_ack) acks++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL full_model got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (!(acks == 4 && mem_req === 1'b0)) begin
            failures++;
            $display("FAIL full_stop acks=%0d req=%b exp=4/0", acks, mem_req);
        end
        popcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL drain_model got=%h exp=%h", obs(), expv());
            end
            if (ir_valid === 1'b1 && popcnt < 4) begin
                checks++;
                if (ir_pc !== 16'(2 * popcnt)) begin
                    failures++;
                    $display("FAIL drain_order got=%h exp=%h",
                             ir_pc, 16'(2 * popcnt));
                end
                popcnt++;
            end
            if (mem_req === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (mem_addr !== 16'h0008) begin
                    failures++;
                    $display("FAIL resume_addr got=%h exp=0008", mem_addr);
                end
            end
            cyc(1'b1, 1'b0, 16'h0);
        end
        checks++;
        if (!(popcnt == 4 && seen)) begin
            failures++;
            $display("FAIL drain_done pops=%0d resumed=%b exp=4/1", popcnt, seen);
        end
    endtask

    task automatic test_latency();
        logic        prev_req;
        logic        prev_ack;
        logic [15:0] prev_addr;
        logic        have;
        logic [15:0] last_pc;
        int          delivered;
        lat_lo = 2; lat_hi = 2; dmask = 16'h1234;
        do_reset();
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0;
        have = 1'b0; last_pc = 16'h0; delivered = 0;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL lat_model got=%h exp=%h", obs(), expv());
            end
            if (mem_req === 1'b1 && prev_req && !prev_ack) begin
                checks++;
                if (mem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL lat_hold got=%h exp=%h", mem_addr, prev_addr);
                end
            end
            if (ir_valid === 1'b1) begin
                if (have) begin
                    checks++;
                    if (ir_pc !== last_pc + 16'd2) begin
                        failures++;
                        $display("FAIL lat_pc got=%h exp=%h",
                                 ir_pc, last_pc + 16'd2);
                    end
                end
                have = 1'b1;
                last_pc = ir_pc;
                delivered++;
            end
            prev_req = (mem_req === 1'b1);
            prev_addr = mem_addr;
            cyc(1'b1, 1'b0, 16'h0);
            prev_ack = last_ack;
        end
        checks++;
        if (delivered < 6 || delivered > 8) begin
            failures++;
            $display("FAIL lat_rate got=%0d exp=6..8", delivered);
        end
    endtask

    task automatic test_redirect_wait();
        logic found;
        lat_lo = 2; lat_hi = 2; dmask = 16'h0F0F;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_req === 1'b1 && mem_addr === 16'h0006 && wcnt == 1) found = 1'b1;
            else cyc(1'b0, 1'b0, 16'h0);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rw_reach got=0 exp=1");
        end
        cyc(1'b0, 1'b1, 16'h0041);
        checks++;
        if (!(ir_valid === 1'b0 && mem_req === 1'b1 && mem_addr === 16'h0006)) begin
            failures++;
            $display("FAIL rw_flush got=%b/%b/%h exp=0/1/0006",
                     ir_valid, mem_req, mem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rw_model got=%h exp=%h", obs(), expv());
            end
            if (mem_req === 1'b1 && mem_addr !== 16'h0006) found = 1'b1;
            else cyc(1'b1, 1'b0, 16'h0);
        end
        checks++;
        if (!(found && mem_addr === 16'h0040)) begin
            failures++;
            $display("FAIL rw_target got=%b/%h exp=1/0040", found, mem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ir_valid === 1'b1) found = 1'b1;
            else cyc(1'b1, 1'b0, 16'h0);
        end
        checks++;
        if (!(found && ir_pc === 16'h0040)) begin
            failures++;
            $display("FAIL rw_first got=%b/%h exp=1/0040", found, ir_pc);
        end
    endtask

    task automatic test_redirect_ack();
        logic [15:0] rpc;
        logic        found;
        lat_lo = 0; lat_hi = 0; dmask = 16'hBEEF;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 16'h0);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL ra_model got=%h exp=%h", obs(), expv());
            end
        end
        checks++;
        if (!(mem_req === 1'b1 && ir_valid === 1'b1)) begin
            failures++;
            $display("FAIL ra_pre got=%b/%b exp=1/1", mem_req, ir_valid);
        end
        rpc = 16'($urandom) | 16'h0101;
        cyc(1'b1, 1'b1, rpc);
        checks++;
        if (!(ir_valid === 1'b0 && mem_req === 1'b1
              && mem_addr === (rpc & 16'hFFFE))) begin
            failures++;
            $display("FAIL ra_next got=%b/%b/%h exp=0/1/%h",
                     ir_valid, mem_req, mem_addr, rpc & 16'hFFFE);
        end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ir_valid === 1'b1) found = 1'b1;
            else cyc(1'b1, 1'b0, 16'h0);
        end
        checks++;
        if (!(found && ir_pc === (rpc & 16'hFFFE))) begin
            failures++;
            $display("FAIL ra_first got=%b/%h exp=1/%h",
                     found, ir_pc, rpc & 16'hFFFE);
        end
    endtask

    task automatic test_wrap_reset();
        logic [15:0] expw [3];
        int          n;
        logic        found;
        expw[0] = 16'hFFFC; expw[1] = 16'hFFFE; expw[2] = 16'h0000;
        lat_lo = 0; lat_hi = 0; dmask = 16'h5A5A;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'hFFFC);
        n = 0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL wrap_model got=%h exp=%h", obs(), expv());
            end
            if (ir_valid === 1'b1) begin
                checks++;
                if (ir_pc !== expw[n]) begin
                    failures++;
                    $display("FAIL wrap_pc got=%h exp=%h", ir_pc, expw[n]);
                end
                n++;
            end
            cyc(1'b1, 1'b0, 16'h0);
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL wrap_count got=%0d exp=3", n);
        end
        lat_lo = 3; lat_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_req === 1'b1 && ir_valid === 1'b1 && lat == 3 && wcnt == 1)
                found = 1'b1;
            else cyc(1'b0, 1'b0, 16'h0);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL areset_reach got=0 exp=1");
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (!(mem_req === 1'b0 && ir_valid === 1'b0)) begin
            failures++;
            $display("FAIL areset_now got=%b/%b exp=0/0", mem_req, ir_valid);
        end
        lat_lo = 0; lat_hi = 0;
        do_reset();
        cyc(1'b1, 1'b0, 16'h0);
        checks++;
        if (!(mem_req === 1'b1 && mem_addr === 16'h0000)) begin
            failures++;
            $display("FAIL areset_restart got=%b/%h exp=1/0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_random();
        int   pr;
        logic rdy;
        logic rd;
        lat_lo = 0; lat_hi = 3; dmask = 16'($urandom);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) pr = (i / 300) % 3 == 0 ? 15 : ((i / 300) % 3 == 1 ? 70 : 100);
            rdy = $urandom_range(99, 0) < pr;
            rd = ($urandom_range(11, 0) == 0);
            cyc(rdy, rd, 16'($urandom));
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rand_model cyc=%0d got=%h exp=%h", i, obs(), expv());
            end
        end
    endtask

    initial begin
        pr_init();
        test_reset();
        test_stream();
        test_full();
        test_latency();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic pr_init();
        lat_lo = 0;
        lat_hi = 0;
        lat = 0;
        wcnt = 0;
    endtask

endmodule
